// File: rtl/inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// inv_cipher_iter -- iterative AES-128 inverse cipher.
//
// Takes one 128-bit ciphertext block and returns its plaintext. One
// decryption round is computed per enabled cycle. Round keys are fetched
// combinationally from an external key store addressed by rk_idx_o.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           global enable; while low every register holds
//   valid_i      state_i carries a ciphertext block
//   ready_o      block is IDLE and can accept a ciphertext
//   state_i      ciphertext, bits [127:120] = byte 0 (column-major)
//   rk_idx_o     index (0..10) of the round key needed this cycle
//   round_key_i  round key for rk_idx_o, same cycle
//   valid_o      one enabled-cycle pulse: state_o holds a new plaintext
//   state_o      plaintext, held until the next result
//
// Build option
//   AES_DEC_SBOX_REG_EN  registers the InvSubBytes output and splits every
//                        round into two enabled cycles (phase bit ph).
//                        Latency becomes 20 enabled edges instead of 10.
// ---------------------------------------------------------------------------
module inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] state_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] round_key_i,
    output logic         valid_o,
    output logic [127:0] state_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] LAST_RK   = 4'(NR);
    localparam logic [3:0] FIRST_RND = 4'(NR - 1);

    // GF(2^8) multiply, polynomial 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = gmul(x, x);
        r  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Row r rotates right by r byte positions; byte index = row + 4*col.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] in);
        logic [127:0] out;
        out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                out[127 - 8*(r + 4*c) -: 8] = in[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return out;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] in);
        logic [127:0] out;
        out = '0;
        for (int k = 0; k < 16; k++) begin
            out[127 - 8*k -: 8] = inv_sbox(in[127 - 8*k -: 8]);
        end
        return out;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] in);
        logic [127:0] out;
        logic [7:0]   a0, a1, a2, a3;
        out = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = in[127 - 32*c -: 8];
            a1 = in[119 - 32*c -: 8];
            a2 = in[111 - 32*c -: 8];
            a3 = in[103 - 32*c -: 8];
            out[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            out[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            out[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            out[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return out;
    endfunction

    logic [0:0]   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic         valid_q, valid_d;
    logic [127:0] out_q, out_d;
    logic [127:0] inv_sr_sb;
    logic [127:0] ark;
    logic         step;
`ifdef AES_DEC_SBOX_REG_EN
    logic         ph_q, ph_d;
    logic [127:0] sb_q, sb_d;
`endif

    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        st_d      = st_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        inv_sr_sb = inv_sub_bytes(inv_shift_rows(st_q));
`ifdef AES_DEC_SBOX_REG_EN
        ph_d      = ph_q;
        sb_d      = sb_q;
        ark       = sb_q ^ round_key_i;
        step      = ph_q;
`else
        ark       = inv_sr_sb ^ round_key_i;
        step      = 1'b1;
`endif
        case (fsm_q)
            S_IDLE: begin
                // Initial AddRoundKey uses rk10, which rk_idx_o requests in IDLE.
                if (valid_i) begin
                    st_d  = state_i ^ round_key_i;
                    rnd_d = FIRST_RND;
                    fsm_d = S_RUN;
                end
            end
            default: begin
`ifdef AES_DEC_SBOX_REG_EN
                ph_d = ~ph_q;
                if (!ph_q) sb_d = inv_sr_sb;
`endif
                // step marks the cycle that applies the key and finishes the round.
                if (step) begin
                    if (rnd_q != 4'd0) begin
                        st_d  = inv_mix_columns(ark);
                        rnd_d = rnd_q - 4'd1;
                    end else begin
                        out_d   = ark;
                        valid_d = 1'b1;
                        fsm_d   = S_IDLE;
                    end
                end
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            rnd_q   <= 4'd0;
            valid_q <= 1'b0;
            out_q   <= '0;
`ifdef AES_DEC_SBOX_REG_EN
            ph_q    <= 1'b0;
`endif
        end else if (en) begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            out_q   <= out_d;
`ifdef AES_DEC_SBOX_REG_EN
            ph_q    <= ph_d;
`endif
        end
    end

    // Working-state datapath registers
    always_ff @(posedge clk) begin
        if (en) begin
            st_q <= st_d;
`ifdef AES_DEC_SBOX_REG_EN
            sb_q <= sb_d;
`endif
        end
    end

    assign ready_o  = (fsm_q == S_IDLE);
    assign rk_idx_o = (fsm_q == S_IDLE) ? LAST_RK : rnd_q;
    assign valid_o  = valid_q;
    assign state_o  = out_q;

endmodule
